// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: in-order write-back FIFO feeding the register file write port with RAW lookup.
// Macro WB_BYPASS_EN builds the Hit/Fwd lookup comparators; undefined ties Hit/Fwd to 0.
module regfile_wb_queue #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [ADDR_W-1:0] InAd,
  input  logic [DATA_W-1:0] InData,
  input  logic              DrainEn,
  output logic              W,
  output logic [ADDR_W-1:0] WAd,
  output logic [DATA_W-1:0] Data,
  input  logic [ADDR_W-1:0] R1,
  input  logic [ADDR_W-1:0] R2,
  output logic              Hit1,
  output logic              Hit2,
  output logic [DATA_W-1:0] Fwd1,
  output logic [DATA_W-1:0] Fwd2,
  output logic [ADDR_W-1:0] Count
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] r_ad   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_vld;
  logic [PW-1:0]     r_wp, r_rp;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_push, w_pop, w_empty, w_full;
  assign w_full  = r_cnt == ADDR_W'(DEPTH);
  assign w_empty = r_cnt == '0;
  assign InReady = !Rst && !w_full;
  assign W       = DrainEn && !w_empty && !Rst;
  assign w_push  = InValid && InReady;
  assign w_pop   = W;
  assign WAd     = w_empty ? '0 : r_ad[r_rp];
  assign Data    = w_empty ? '0 : r_data[r_rp];
  assign Count   = r_cnt;
  // Entry payloads are deliberately left out of reset; only valid bits and pointers clear.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_vld <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_rp] <= 1'b0;
        r_rp        <= r_rp + PW'(1);
      end
      if (w_push) begin
        r_ad[r_wp]   <= InAd;
        r_data[r_wp] <= InData;
        r_vld[r_wp]  <= 1'b1;
        r_wp         <= r_wp + PW'(1);
      end
      r_cnt <= r_cnt + ADDR_W'(w_push) - ADDR_W'(w_pop);
    end
  end
`ifdef WB_BYPASS_EN
  logic [PW-1:0]     w_idx;
  logic              w_hit1, w_hit2;
  logic [DATA_W-1:0] w_fwd1, w_fwd2;
  // Walk oldest to youngest so the last match wins.
  always_comb begin
    w_idx  = '0;
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_fwd1 = '0;
    w_fwd2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rp + PW'(k);
      if (r_vld[w_idx] && r_ad[w_idx] == R1) begin
        w_hit1 = 1'b1;
        w_fwd1 = r_data[w_idx];
      end
      if (r_vld[w_idx] && r_ad[w_idx] == R2) begin
        w_hit2 = 1'b1;
        w_fwd2 = r_data[w_idx];
      end
    end
  end
  assign Hit1 = w_hit1 && !Rst;
  assign Hit2 = w_hit2 && !Rst;
  assign Fwd1 = Rst ? '0 : w_fwd1;
  assign Fwd2 = Rst ? '0 : w_fwd2;
`else
  logic w_unused;
  assign w_unused = ^{R1, R2, r_vld};
  assign Hit1 = 1'b0;
  assign Hit2 = 1'b0;
  assign Fwd1 = '0;
  assign Fwd2 = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb_regfile_wb_queue: directed-vector bench for regfile_wb_queue.
module tb_regfile_wb_queue;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic        Clk = 1'b0, Rst = 1'b1, InValid = 1'b0, DrainEn = 1'b0;
  logic        InReady, W, Hit1, Hit2;
  logic [4:0]  InAd = '0, R1 = '0, R2 = '0, WAd, Count;
  logic [31:0] InData = '0, Data, Fwd1, Fwd2;
  int          checks = 0, failures = 0, wseen;
  int          exp_ad [5] = '{6, 7, 8, 9, 10};

  regfile_wb_queue dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady), .InAd(InAd),
    .InData(InData), .DrainEn(DrainEn), .W(W), .WAd(WAd), .Data(Data),
    .R1(R1), .R2(R2), .Hit1(Hit1), .Hit2(Hit2), .Fwd1(Fwd1), .Fwd2(Fwd2),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge Clk);
  endtask

  task automatic push(input logic [4:0] ad, input logic [31:0] d);
    InValid = 1'b1; InAd = ad; InData = d;
    nxt();
    InValid = 1'b0;
  endtask

  initial begin
    DrainEn = 1'b1;
    nxt(); #1;
    chk("rst_ready", InReady, 0);
    chk("rst_w", W, 0);
    chk("rst_count", Count, 0);
    chk("rst_hit1", Hit1, 0);
    chk("rst_fwd1", Fwd1, 0);
    nxt();
    Rst = 1'b0; InValid = 1'b1; InAd = 5'd18; InData = 32'd7; #1;
    chk("t1_ready", InReady, 1);
    chk("t1_w_pre", W, 0);
    nxt();
    InValid = 1'b0; R1 = 5'd18; #1;
    chk("t1_w", W, 1);
    chk("t1_wad", WAd, 18);
    chk("t1_data", Data, 7);
    chk("t1_count", Count, 1);
    chk("t1_hit1", Hit1, BYP ? 1 : 0);
    chk("t1_fwd1", Fwd1, BYP ? 7 : 0);
    nxt(); #1;
    chk("t1_w_after", W, 0);
    chk("t1_count_after", Count, 0);
    chk("t1_wad_empty", WAd, 0);

    DrainEn = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      #1 chk("t2_ready", InReady, 1);
      push(5'(i), 32'(10 * i));
    end
    InValid = 1'b1; InAd = 5'd5; InData = 32'd50; #1;
    chk("t2_full_count", Count, 4);
    chk("t2_full_ready", InReady, 0);
    chk("t2_full_w", W, 0);
    nxt(); #1;
    chk("t2_fifth_ignored", Count, 4);
    InValid = 1'b0; DrainEn = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("t2_w", W, 1);
      chk("t2_wad", WAd, 32'(i));
      chk("t2_data", Data, 32'(10 * i));
      nxt();
    end
    #1 chk("t2_empty_count", Count, 0);
    chk("t2_empty_w", W, 0);

    DrainEn = 1'b0;
    push(5'd6, 32'd60);
    push(5'd7, 32'd70);
    DrainEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      InValid = 1'b1; InAd = 5'(8 + i); InData = 32'(80 + 10 * i); #1;
      chk("t3_count", Count, 2);
      chk("t3_w", W, 1);
      chk("t3_wad", WAd, 32'(exp_ad[i]));
      chk("t3_data", Data, 32'(10 * exp_ad[i]));
      nxt();
    end
    InValid = 1'b0;
    for (int i = 3; i < 5; i++) begin
      #1;
      chk("t3_wad", WAd, 32'(exp_ad[i]));
      chk("t3_data", Data, 32'(10 * exp_ad[i]));
      nxt();
    end
    #1 chk("t3_count_end", Count, 0);

    DrainEn = 1'b0;
    push(5'd17, 32'd4);
    push(5'd17, 32'd9);
    R1 = 5'd17; R2 = 5'd16; #1;
    chk("t4_hit1", Hit1, BYP ? 1 : 0);
    chk("t4_fwd1", Fwd1, BYP ? 9 : 0);
    chk("t4_hit2", Hit2, 0);
    chk("t4_fwd2", Fwd2, 0);
    DrainEn = 1'b1; #1;
    chk("t4_w0", W, 1);
    chk("t4_wad0", WAd, 17);
    chk("t4_data0", Data, 4);
    chk("t4_fwd_popping", Fwd1, BYP ? 9 : 0);
    nxt(); #1;
    chk("t4_data1", Data, 9);
    chk("t4_hit_head_pop", Hit1, BYP ? 1 : 0);
    chk("t4_fwd_head_pop", Fwd1, BYP ? 9 : 0);
    nxt(); #1;
    chk("t4_hit1_gone", Hit1, 0);
    chk("t4_fwd1_gone", Fwd1, 0);

    DrainEn = 1'b0;
    push(5'd20, 32'd1);
    push(5'd21, 32'd2);
    push(5'd22, 32'd3);
    R1 = 5'd20; R2 = 5'd22; #1;
    chk("t5_count_pre", Count, 3);
    chk("t5_hit2_pre", Hit2, BYP ? 1 : 0);
    Rst = 1'b1; DrainEn = 1'b1; #1;
    chk("t5_rst_w", W, 0);
    chk("t5_rst_ready", InReady, 0);
    chk("t5_rst_hit1", Hit1, 0);
    nxt();
    Rst = 1'b0; wseen = 0;
    for (int i = 0; i < 4; i++) begin
      #1 wseen += int'(W);
      nxt();
    end
    #1;
    chk("t5_count", Count, 0);
    chk("t5_no_commit", wseen, 0);
    chk("t5_hit1", Hit1, 0);
    chk("t5_hit2", Hit2, 0);
    chk("t5_ready", InReady, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side front end for the 32x32 register file.
- Accepts register write-back requests from the execute/memory stages over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains one entry per enabled cycle onto the register file write port (W, WAd, Data).
- Provides read-after-write lookup so the read side sees pending values before they are committed.

Parameters:
- DATA_W, 32, width of register data.
- ADDR_W, 5, width of register address (32 registers).
- DEPTH, 4, number of FIFO entries; power of two, at least 2.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  synchronous active-high reset.
- InValid  input  1  write-back request present.
- InReady  output  1  queue can accept a request this cycle.
- InAd  input  ADDR_W  destination register of request.
- InData  input  DATA_W  value to write.
- DrainEn  input  1  register file write port free this cycle.
- W  output  1  write strobe to register file.
- WAd  output  ADDR_W  write address to register file.
- Data  output  DATA_W  write data to register file.
- R1  input  ADDR_W  lookup address, port 1.
- R2  input  ADDR_W  lookup address, port 2.
- Hit1  output  1  pending write to R1 exists.
- Hit2  output  1  pending write to R2 exists.
- Fwd1  output  DATA_W  youngest pending value for R1.
- Fwd2  output  DATA_W  youngest pending value for R2.
- Count  output  ADDR_W  number of occupied entries, 0..DEPTH.

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst is synchronous and active-high.
- Reset: on a Clk edge with Rst=1, read/write pointers and Count clear to 0 and all entry valid bits clear. Entry data is not cleared.
- During and after reset: W=0, Hit1=Hit2=0, Fwd1=Fwd2=0, InReady=0 while Rst=1, InReady=1 on the first cycle after Rst falls.
- Reset mid-operation: pending entries are discarded and never written.
- Push: a push occurs when InValid && InReady at a Clk edge. {InAd, InData} is stored at the write pointer and the pointer advances, wrapping modulo DEPTH.
- InReady = !Rst && (Count != DEPTH). Readiness does not depend on a same-cycle pop.
- Drain: W = DrainEn && (Count != 0) && !Rst, combinational. WAd and Data show the head entry whenever Count != 0, else 0.
- Pop: a pop occurs on a Clk edge where W=1; the read pointer advances, wrapping. The register file captures WAd/Data on the same edge.
- Simultaneous push and pop: Count unchanged; both pointers advance.
- Latency: an entry pushed at edge N is visible on W/WAd/Data in cycle N+1 if it becomes the head and DrainEn=1. Minimum push-to-commit is 2 edges.
- Order: strictly in-order. Multiple pending writes to the same address commit oldest first.
- Full: Count=DEPTH, InReady=0; InValid is ignored and the producer must hold it.
- Empty: Count=0, W=0 regardless of DrainEn.
- Lookup: Hit1/Fwd1 and Hit2/Fwd2 are combinational over valid entries only.
  - On multiple matches, Fwd returns the youngest entry, i.e. the most recently pushed.
  - With no match, Fwd=0.
  - The head entry being popped this cycle still counts as a match in that cycle.
  - A request being pushed this cycle is not visible until the next cycle.
- Address 0 is treated like any other register; no hardwired-zero handling.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined: lookup logic is built as described above.
- Undefined: no comparators are built; Hit1=Hit2=0 and Fwd1=Fwd2=0 permanently. Ports remain present and all queue behaviour is unchanged.

Test Plan:
- Reset then single write: Rst 1 cycle, push InAd=18 InData=7 with DrainEn=1 -> next cycle W=1 WAd=18 Data=7, Count=1; following cycle W=0, Count=0.
- Fill to full: DrainEn=0, push 4 requests (Ad 1..4, Data 10..40) -> Count=4, InReady=0. A fifth InValid is not accepted. Raise DrainEn -> W shows Ad 1,2,3,4 in order on consecutive cycles.
- Simultaneous push/pop: Count=2, DrainEn=1, InValid=1 for 3 cycles -> Count stays 2; commits occur in exact push order with pointer wrap exercised.
- Lookup youngest (WB_BYPASS_EN defined): DrainEn=0, push (17,4), then (17,9) -> R1=17 gives Hit1=1 Fwd1=9. R2=16 gives Hit2=0 Fwd2=0.
- Lookup disabled (WB_BYPASS_EN undefined): same stimulus -> Hit1=0 Fwd1=0; commits still 4 then 9 to register 17.
- Reset mid-operation: 3 entries pending, assert Rst for one edge -> Count=0, W=0, Hit1=Hit2=0; none of the 3 writes ever appear on W.
